// File: rtl/zynq_pkg.sv
// zynq_pkg: shared credit-gate constants and FSM state encoding.
package zynq_pkg;
  localparam int max_credits_gp = 32;
  localparam logic [15:0] rev_drain_timeout_gp = 16'hFFFF;
  typedef enum logic [1:0] {e_rev_run, e_rev_drain, e_rev_done} zynq_rev_gate_state_e;
endpackage

// File: rtl/zynq_credit_counter.sv
// zynq_credit_counter: saturating up/down outstanding counter with underflow flag.
module zynq_credit_counter #(
  parameter int max_p = 32,
  parameter int width_p = $clog2(max_p + 1)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               up,
  input  logic               down,
  output logic [width_p-1:0] count,
  output logic [width_p-1:0] count_next,
  output logic               underflow
);
  assign underflow = down & (count == '0);
  always_comb
    count_next = (up & ~down & (count != width_p'(max_p))) ? count + 1'b1 :
                 (down & ~up & (count != '0)) ? count - 1'b1 : count;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) count <= '0;
    else count <= count_next;
endmodule

// File: rtl/zynq_rev_credit_gate.sv
// zynq_rev_credit_gate: credit gate with drain fence on the PS request path.
// Optional drain watchdog: define ZYNQ_REV_CREDIT_TIMEOUT_EN.
module zynq_rev_credit_gate
  import zynq_pkg::*;
#(
  parameter int data_width_p = 128,
  parameter int max_credits_p = max_credits_gp,
  localparam int credit_width_lp = $clog2(max_credits_p + 1)
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [data_width_p-1:0]    data_i,
  input  logic                       v_i,
  output logic                       ready_o,
  output logic [data_width_p-1:0]    data_o,
  output logic                       v_o,
  input  logic                       ready_i,
  input  logic                       credit_v_i,
  input  logic                       drain_i,
  output logic                       drain_done_o,
  output logic [credit_width_lp-1:0] outstanding_o,
  output logic                       err_o
);
  zynq_rev_gate_state_e state;
  logic allow, fire, underflow, wd_hit;
  logic [credit_width_lp-1:0] count_next;
  assign allow = (outstanding_o < credit_width_lp'(max_credits_p)) && (state == e_rev_run);
  assign fire = v_i & ready_i & allow;
  assign data_o = data_i;
  assign v_o = v_i & allow;
  assign ready_o = ready_i & allow;
  zynq_credit_counter #(.max_p(max_credits_p), .width_p(credit_width_lp)) counter (
    .aclk(aclk),
    .aresetn(aresetn),
    .up(fire),
    .down(credit_v_i),
    .count(outstanding_o),
    .count_next(count_next),
    .underflow(underflow)
  );
`ifdef ZYNQ_REV_CREDIT_TIMEOUT_EN
  logic [15:0] wd;
  // cleared while not draining, so every entry into DRAIN starts from zero
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) wd <= '0;
    else wd <= (state == e_rev_drain) ? wd + 16'd1 : '0;
  assign wd_hit = (state == e_rev_drain) && (wd == rev_drain_timeout_gp);
`else
  assign wd_hit = 1'b0;
`endif
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= e_rev_run;
      err_o <= 1'b0;
      drain_done_o <= 1'b0;
    end else begin
      err_o <= err_o | underflow | wd_hit;
      drain_done_o <= state == e_rev_done;
      case (state)
        e_rev_run:   state <= drain_i ? e_rev_drain : e_rev_run;
        e_rev_drain: state <= !drain_i ? e_rev_run :
                              ((count_next == '0) || wd_hit) ? e_rev_done : e_rev_drain;
        default:     state <= drain_i ? e_rev_done : e_rev_run;
      endcase
    end
endmodule

// File: tb/tb_zynq_rev_credit_gate.sv
// tb_zynq_rev_credit_gate: scoreboard bench with a cycle-level reference model.
module tb_zynq_rev_credit_gate;
  localparam int MAX = 32;
`ifdef ZYNQ_REV_CREDIT_TIMEOUT_EN
  localparam bit timeout_en = 1'b1;
`else
  localparam bit timeout_en = 1'b0;
`endif
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [127:0] data_i = '0, data_o;
  logic v_i = 0, ready_i = 0, credit_v_i = 0, drain_i = 0;
  logic ready_o, v_o, drain_done_o, err_o;
  logic [5:0] outstanding_o;
  typedef struct {
    logic v; logic r; logic [127:0] d; int o; logic e; logic dd;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int m_out = 0, m_mode = 0, m_wd = 0;
  bit m_err = 0, m_dd = 0;

  zynq_rev_credit_gate dut (
    .aclk(aclk), .aresetn(aresetn), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .data_o(data_o), .v_o(v_o), .ready_i(ready_i), .credit_v_i(credit_v_i),
    .drain_i(drain_i), .drain_done_o(drain_done_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 aclk = ~aclk;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // mode: 0 = forwarding, 1 = fencing, 2 = fence complete
  task automatic cycle(bit rst_n, bit v, bit rdy, bit cr, bit dr);
    exp_t e;
    bit allow, fire, hit;
    int nm;
    @(negedge aclk);
    aresetn = rst_n; v_i = v; ready_i = rdy; credit_v_i = cr; drain_i = dr;
    data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (!rst_n) begin m_out = 0; m_err = 0; m_dd = 0; m_mode = 0; m_wd = 0; end
    allow = (m_out < MAX) && (m_mode == 0);
    e.v = v && allow; e.r = rdy && allow; e.d = data_i; e.o = m_out; e.e = m_err; e.dd = m_dd;
    q.push_back(e);
    @(posedge aclk);
    if (rst_n) begin
      fire = v && rdy && allow;
      hit = timeout_en && m_mode == 1 && m_wd == 65535;
      if ((cr && m_out == 0) || hit) m_err = 1;
      if (fire && !cr) m_out++;
      else if (cr && !fire && m_out > 0) m_out--;
      m_dd = m_mode == 2;
      if (m_mode == 0) nm = dr ? 1 : 0;
      else if (m_mode == 1) nm = !dr ? 0 : (m_out == 0 || hit) ? 2 : 1;
      else nm = dr ? 2 : 0;
      m_wd = (m_mode == 1) ? m_wd + 1 : 0;
      m_mode = nm;
    end
  endtask

  initial forever begin
    @(negedge aclk);
    #2;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("v_o", 128'(v_o), 128'(e.v));
      chk("ready_o", 128'(ready_o), 128'(e.r));
      chk("data_o", data_o, e.d);
      chk("outstanding_o", 128'(outstanding_o), 128'(e.o));
      chk("err_o", 128'(err_o), 128'(e.e));
      chk("drain_done_o", 128'(drain_done_o), 128'(e.dd));
    end
  end

  initial begin
    bit dr_r;
    repeat (2) cycle(0, 0, 0, 0, 0);
    repeat (33) cycle(1, 1, 1, 0, 0);
    cycle(1, 0, 1, 1, 0);
    cycle(1, 1, 1, 0, 0);
    repeat (2) cycle(1, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    repeat (5) cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 1, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    repeat (3) cycle(1, 1, 1, 0, 0);
    cycle(1, 0, 0, 0, 1);
    repeat (3) cycle(1, 1, 1, 1, 1);
    repeat (3) cycle(1, 1, 1, 0, 1);
    repeat (2) cycle(1, 0, 0, 0, 0);
    repeat (2) cycle(1, 1, 1, 0, 0);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    repeat (4) cycle(1, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    dr_r = 0;
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) dr_r = !dr_r;
      cycle($urandom_range(0, 299) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, dr_r);
    end
    if (timeout_en) begin
      cycle(0, 0, 0, 0, 0);
      cycle(1, 1, 1, 0, 0);
      repeat (65540) cycle(1, 0, 0, 0, 1);
      repeat (2) cycle(1, 1, 1, 0, 0);
      cycle(1, 0, 0, 0, 1);
      repeat (10) cycle(1, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      repeat (2) cycle(1, 1, 1, 0, 0);
    end
    @(negedge aclk);
    #5;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
